// File: rtl/gpio_bus_arbiter.sv
// rtl/gpio_bus_arbiter.sv - two-master round-robin arbiter for the GPIO peripheral bus
module gpio_bus_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ACCESS_WAIT = 0
) (
    input  logic                  CoreClock,
    input  logic                  Reset,
    input  logic                  M0_Req,
    input  logic [ADDR_WIDTH-1:0] M0_Addr,
    input  logic [DATA_WIDTH-1:0] M0_WData,
    input  logic                  M0_Write,
    output logic                  M0_Ack,
    output logic [DATA_WIDTH-1:0] M0_RData,
    input  logic                  M1_Req,
    input  logic [ADDR_WIDTH-1:0] M1_Addr,
    input  logic [DATA_WIDTH-1:0] M1_WData,
    input  logic                  M1_Write,
    output logic                  M1_Ack,
    output logic [DATA_WIDTH-1:0] M1_RData,
    output logic [ADDR_WIDTH-1:0] AddressBus,
    output logic [DATA_WIDTH-1:0] DataWriteBus,
    output logic                  WriteAssert,
    input  logic [DATA_WIDTH-1:0] DataReadBus,
    output logic                  Busy,
    output logic                  GrantOwner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(ACCESS_WAIT);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  write_q, write_d;
    logic [3:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  m0_ack_q, m0_ack_d;
    logic                  m1_ack_q, m1_ack_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;

    // On a tie the master that did not own the last transaction wins.
    logic pick_m1;
    logic sel_write;
    assign pick_m1   = M1_Req && (!M0_Req || !owner_q);
    assign sel_write = pick_m1 ? M1_Write : M0_Write;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        write_d    = write_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if (M0_Req || M1_Req) begin
                    owner_d = pick_m1;
                    write_d = sel_write;
                    addr_d  = pick_m1 ? M1_Addr : M0_Addr;
                    wdata_d = sel_write ? (pick_m1 ? M1_WData : M0_WData) : '0;
                    wait_d  = WAIT_INIT;
                    we_d    = sel_write && (WAIT_INIT == 4'd0);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                    // Strobe is registered, so raise it one edge ahead of the final cycle.
                    we_d   = write_q && (wait_q == 4'd1);
                end else begin
                    state_d = RESP;
                    if (owner_q) begin
                        m1_ack_d = 1'b1;
                        if (!write_q) m1_rdata_d = DataReadBus;
                    end else begin
                        m0_ack_d = 1'b1;
                        if (!write_q) m0_rdata_d = DataReadBus;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b1;
            write_q    <= 1'b0;
            wait_q     <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            write_q    <= write_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign M0_Ack       = m0_ack_q;
    assign M1_Ack       = m1_ack_q;
    assign M0_RData     = m0_rdata_q;
    assign M1_RData     = m1_rdata_q;
    assign AddressBus   = addr_q;
    assign DataWriteBus = wdata_q;
    assign WriteAssert  = we_q;
    assign Busy         = (state_q != IDLE);
    assign GrantOwner   = owner_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb/tb_gpio_bus_arbiter.sv - scoreboard bench for gpio_bus_arbiter (zero-wait and 3-wait instances)
module tb_gpio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_a, m1_req_a, m0_req_b, m1_req_b;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_write, m1_write;

    logic        a_m0_ack, a_m1_ack, a_wa, a_busy, a_owner;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_addr, a_wdb, drb_a;
    logic        b_m0_ack, b_m1_ack, b_wa, b_busy, b_owner;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_addr, b_wdb, drb_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        master;
        logic        is_read;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    gpio_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACCESS_WAIT(0)) dut_a (
        .CoreClock(clk), .Reset(rst),
        .M0_Req(m0_req_a), .M0_Addr(m0_addr), .M0_WData(m0_wdata), .M0_Write(m0_write),
        .M0_Ack(a_m0_ack), .M0_RData(a_m0_rdata),
        .M1_Req(m1_req_a), .M1_Addr(m1_addr), .M1_WData(m1_wdata), .M1_Write(m1_write),
        .M1_Ack(a_m1_ack), .M1_RData(a_m1_rdata),
        .AddressBus(a_addr), .DataWriteBus(a_wdb), .WriteAssert(a_wa),
        .DataReadBus(drb_a), .Busy(a_busy), .GrantOwner(a_owner)
    );

    gpio_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACCESS_WAIT(3)) dut_b (
        .CoreClock(clk), .Reset(rst),
        .M0_Req(m0_req_b), .M0_Addr(m0_addr), .M0_WData(m0_wdata), .M0_Write(m0_write),
        .M0_Ack(b_m0_ack), .M0_RData(b_m0_rdata),
        .M1_Req(m1_req_b), .M1_Addr(m1_addr), .M1_WData(m1_wdata), .M1_Write(m1_write),
        .M1_Ack(b_m1_ack), .M1_RData(b_m1_rdata),
        .AddressBus(b_addr), .DataWriteBus(b_wdb), .WriteAssert(b_wa),
        .DataReadBus(drb_b), .Busy(b_busy), .GrantOwner(b_owner)
    );

    // Small register-file peripheral behind instance A; 0x1000 is a fixed status word.
    logic [31:0] periph [0:15];
    always @(posedge clk) if (a_wa) periph[a_addr[5:2]] <= a_wdb;
    assign drb_a = (a_addr == 32'h0000_1000) ? 32'h0000_0155 : periph[a_addr[5:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic master, input logic is_read, input logic [31:0] rdata);
        exp_t e;
        e.master  = master;
        e.is_read = is_read;
        e.rdata   = rdata;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (a_m0_ack || a_m1_ack) begin
            exp_t e;
            chk("ack_overlap", {31'b0, a_m0_ack & a_m1_ack}, 32'd0);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ack_master", {31'b0, a_m1_ack}, {31'b0, e.master});
                chk("ack_owner", {31'b0, a_owner}, {31'b0, e.master});
                if (e.is_read)
                    chk("ack_rdata", e.master ? a_m1_rdata : a_m0_rdata, e.rdata);
            end
        end
    end

    initial begin
        int n0, n1;
        bit re0, re1;
        int ack_t[$];

        rst = 1'b1;
        {m0_req_a, m1_req_a, m0_req_b, m1_req_b} = 4'b0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata} = '0;
        {m0_write, m1_write} = 2'b0;
        drb_b = 32'd0;
        step(); step();
        chk("rst_addr", a_addr, 32'd0);
        chk("rst_wdb", a_wdb, 32'd0);
        chk("rst_wa", {31'b0, a_wa}, 32'd0);
        chk("rst_acks", {30'b0, a_m0_ack, a_m1_ack}, 32'd0);
        chk("rst_rdata", a_m0_rdata | a_m1_rdata, 32'd0);
        chk("rst_busy", {31'b0, a_busy}, 32'd0);
        chk("rst_owner", {30'b0, a_owner, b_owner}, 32'd3);
        rst = 1'b0;

        // single write, zero wait
        m0_addr = 32'h0; m0_wdata = 32'hA5; m0_write = 1'b1; m0_req_a = 1'b1;
        push(1'b0, 1'b0, 32'd0);
        chk("wr_idle_busy", {31'b0, a_busy}, 32'd0);
        step();
        chk("wr_wa_n1", {31'b0, a_wa}, 32'd1);
        chk("wr_addr_n1", a_addr, 32'h0);
        chk("wr_wdb_n1", a_wdb, 32'hA5);
        chk("wr_busy_n1", {31'b0, a_busy}, 32'd1);
        chk("wr_ack_n1", {31'b0, a_m0_ack}, 32'd0);
        step();
        chk("wr_wa_n2", {31'b0, a_wa}, 32'd0);
        chk("wr_ack_n2", {31'b0, a_m0_ack}, 32'd1);
        chk("wr_busy_n2", {31'b0, a_busy}, 32'd1);
        m0_req_a = 1'b0;
        step();
        chk("wr_busy_n3", {31'b0, a_busy}, 32'd0);
        chk("wr_ack_n3", {31'b0, a_m0_ack}, 32'd0);

        // M1 read of the fixed status word; write data must be zeroed on a read
        m1_addr = 32'h1000; m1_wdata = 32'hFFFF_FFFF; m1_write = 1'b0; m1_req_a = 1'b1;
        push(1'b1, 1'b1, 32'h155);
        step();
        chk("rd_wa_n1", {31'b0, a_wa}, 32'd0);
        chk("rd_addr_n1", a_addr, 32'h1000);
        chk("rd_wdb_n1", a_wdb, 32'd0);
        step();
        chk("rd_ack_n2", {31'b0, a_m1_ack}, 32'd1);
        chk("rd_m1_rdata", a_m1_rdata, 32'h155);
        chk("rd_m0_rdata_kept", a_m0_rdata, 32'd0);
        chk("rd_wa_n2", {31'b0, a_wa}, 32'd0);
        m1_req_a = 1'b0;
        step();

        // read-after-write on the same register
        m0_addr = 32'h0; m0_write = 1'b0; m0_req_a = 1'b1;
        push(1'b0, 1'b1, 32'hA5);
        step(); step();
        chk("raw_m0_rdata", a_m0_rdata, 32'hA5);
        chk("raw_m1_rdata_kept", a_m1_rdata, 32'h155);
        m0_req_a = 1'b0;
        step();

        rst = 1'b1;
        step();
        chk("rst2_owner", {31'b0, a_owner}, 32'd1);
        chk("rst2_rdata", a_m0_rdata | a_m1_rdata, 32'd0);
        rst = 1'b0;

        // contention: M0 writes, M1 reads the same register, alternating
        m0_addr = 32'h4; m0_wdata = 32'h11; m0_write = 1'b1;
        m1_addr = 32'h4; m1_wdata = 32'h0;  m1_write = 1'b0;
        push(1'b0, 1'b0, 32'd0);
        push(1'b1, 1'b1, 32'h11);
        push(1'b0, 1'b0, 32'd0);
        push(1'b1, 1'b1, 32'h33);
        m0_req_a = 1'b1; m1_req_a = 1'b1;
        n0 = 0; n1 = 0; re0 = 0; re1 = 0;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (a_m0_ack) begin
                m0_req_a = 1'b0; n0++; ack_t.push_back(c);
                if (n0 < 2) re0 = 1;
            end else if (re0) begin
                m0_req_a = 1'b1; m0_wdata = 32'h33; re0 = 0;
            end
            if (a_m1_ack) begin
                m1_req_a = 1'b0; n1++; ack_t.push_back(c);
                if (n1 < 2) re1 = 1;
            end else if (re1) begin
                m1_req_a = 1'b1; re1 = 0;
            end
        end
        chk("cont_ack_count", 32'(ack_t.size()), 32'd4);
        for (int i = 0; i < ack_t.size(); i++)
            chk("cont_ack_cycle", 32'(ack_t[i]), 32'(2 + 3 * i));
        chk("cont_busy_end", {31'b0, a_busy}, 32'd0);
        chk("cont_m0_rdata_write_only", a_m0_rdata, 32'd0);
        chk("cont_m1_rdata", a_m1_rdata, 32'h33);

        // one-cycle Req in IDLE still completes
        m0_addr = 32'h4; m0_write = 1'b0; m0_req_a = 1'b1;
        push(1'b0, 1'b1, 32'h33);
        step();
        m0_req_a = 1'b0;
        chk("wd_busy", {31'b0, a_busy}, 32'd1);
        step();
        chk("wd_ack", {31'b0, a_m0_ack}, 32'd1);
        step();

        // Req pulsed only during another master's ACCESS produces nothing
        m1_addr = 32'h8; m1_wdata = 32'h5A; m1_write = 1'b1; m1_req_a = 1'b1;
        push(1'b1, 1'b0, 32'd0);
        step();
        m0_req_a = 1'b1;
        step();
        chk("wd2_m1_ack", {31'b0, a_m1_ack}, 32'd1);
        m0_req_a = 1'b0; m1_req_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wd2_idle", {30'b0, a_busy, a_m0_ack}, 32'd0);
        end

        // instance B: three wait states, inputs changed after grant are ignored
        m0_addr = 32'h8; m0_wdata = 32'h1234; m0_write = 1'b1; m0_req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) begin m0_addr = 32'hFC; m0_wdata = 32'h0; m0_write = 1'b0; end
            chk("ws_addr", b_addr, 32'h8);
            chk("ws_wdb", b_wdb, 32'h1234);
            chk("ws_wa", {31'b0, b_wa}, {31'b0, i == 3});
            chk("ws_ack", {31'b0, b_m0_ack}, 32'd0);
        end
        step();
        chk("ws_ack_n5", {31'b0, b_m0_ack}, 32'd1);
        chk("ws_wa_n5", {31'b0, b_wa}, 32'd0);
        m0_req_b = 1'b0;
        step();
        chk("ws_busy_end", {30'b0, b_busy, b_m0_ack}, 32'd0);

        // read data is captured only at the end of the final ACCESS cycle
        m1_addr = 32'h20; m1_write = 1'b0; drb_b = 32'h1; m1_req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) drb_b = 32'h77;
        end
        step();
        chk("ws_rd_ack", {31'b0, b_m1_ack}, 32'd1);
        chk("ws_rd_rdata", b_m1_rdata, 32'h77);
        chk("ws_rd_m0_kept", b_m0_rdata, 32'd0);
        m1_req_b = 1'b0;
        step();

        // reset in the middle of an M1 write
        m1_addr = 32'h30; m1_wdata = 32'hCAFE; m1_write = 1'b1; m1_req_b = 1'b1;
        step(); step();
        chk("rm_wa_pre", {31'b0, b_wa}, 32'd0);
        rst = 1'b1; m1_req_b = 1'b0;
        step();
        chk("rm_addr", b_addr, 32'd0);
        chk("rm_wdb", b_wdb, 32'd0);
        chk("rm_flags", {28'b0, b_wa, b_m1_ack, b_busy, b_owner}, 32'd1);
        chk("rm_rdata", b_m0_rdata | b_m1_rdata, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rm_quiet", {30'b0, b_wa, b_m1_ack}, 32'd0);
        end
        m0_addr = 32'h40; m0_write = 1'b0; drb_b = 32'h99; m0_req_b = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("rm_fresh_noack", {31'b0, b_m0_ack}, 32'd0);
        step();
        chk("rm_fresh_ack", {31'b0, b_m0_ack}, 32'd1);
        chk("rm_fresh_rdata", b_m0_rdata, 32'h99);
        chk("rm_fresh_owner", {31'b0, b_owner}, 32'd0);
        m0_req_b = 1'b0;
        step(); step();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
